// File: rtl/lif_neuron_scheduler_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron scheduler.
package lif_neuron_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    REPORT = 2'd2
  } sched_state_t;

  localparam int unsigned RESET_THR        = 32;
  localparam int unsigned RESET_LEAK_SHIFT = 1;
  // cfg_addr MSB value that selects the leak_shift register instead of a threshold.
  localparam logic        CFG_SEL_LEAK     = 1'b1;

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron LIF update: fire test on the pre-update state and saturating integrate.
module lif_update #(
  parameter int W = 8
) (
  input  logic [W-1:0] state,
  input  logic [W-1:0] current,
  input  logic [W-1:0] threshold,
  input  logic [W-1:0] leak_shift,
  output logic [W-1:0] next,
  output logic         fire
);

  logic [W-1:0] leak;
  logic [W:0]   sum;

  always_comb begin
    fire = (state >= threshold);
    // A firing neuron drops its carried state; oversized shifts carry nothing.
    if (fire || (int'(leak_shift) >= W)) leak = '0;
    else                                 leak = state >> leak_shift;
    sum  = {1'b0, current} + {1'b0, leak};
    next = sum[W] ? '1 : sum[W-1:0];
  end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Sweeps NUM_NEURONS virtual LIF neurons through one shared update datapath per timestep
// and hands the resulting spike vector to a consumer.
module lif_neuron_scheduler
  import lif_neuron_scheduler_pkg::*;
#(
  parameter  int NUM_NEURONS = 4,
  parameter  int W           = 8,
  localparam int IDXW        = $clog2(NUM_NEURONS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       step,
  input  logic [NUM_NEURONS*W-1:0]   current,
  input  logic                       cfg_we,
  input  logic [IDXW:0]              cfg_addr,
  input  logic [W-1:0]               cfg_data,
  output logic                       busy,
  output logic                       spike_valid,
  input  logic                       spike_ready,
  output logic [NUM_NEURONS-1:0]     spike_vec,
  output logic                       overrun,
  output sched_state_t               fsm_state
);

  // Handshake: spike_valid holds with a stable spike_vec until a rising edge sees
  // spike_valid && spike_ready; that edge completes the transfer and returns to IDLE.

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_NEURONS - 1);

  sched_state_t             fsm_q, fsm_d;
  logic [IDXW-1:0]          idx;
  logic [NUM_NEURONS*W-1:0] cur_shadow;
  logic [W-1:0]             state [NUM_NEURONS];
  logic [W-1:0]             thr   [NUM_NEURONS];
  logic [W-1:0]             leak_shift;
  logic [NUM_NEURONS-1:0]   spike_q;
  logic                     overrun_q;
  logic [W-1:0]             cur_sel;
  logic [W-1:0]             upd_next;
  logic                     upd_fire;

  assign cur_sel = cur_shadow[idx*W +: W];

  lif_update #(.W(W)) u_update (
    .state      (state[idx]),
    .current    (cur_sel),
    .threshold  (thr[idx]),
    .leak_shift (leak_shift),
    .next       (upd_next),
    .fire       (upd_fire)
  );

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (step)              fsm_d = UPDATE;
      UPDATE:  if (idx == LAST_IDX)   fsm_d = REPORT;
      REPORT:  if (spike_ready)       fsm_d = IDLE;
      default:                        fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q      <= IDLE;
      idx        <= '0;
      cur_shadow <= '0;
      spike_q    <= '0;
      overrun_q  <= 1'b0;
      leak_shift <= W'(RESET_LEAK_SHIFT);
      for (int i = 0; i < NUM_NEURONS; i++) begin
        state[i] <= '0;
        thr[i]   <= W'(RESET_THR);
      end
    end else begin
      fsm_q <= fsm_d;
      if (step && (fsm_q != IDLE)) overrun_q <= 1'b1;
      case (fsm_q)
        IDLE: begin
          if (step) begin
            cur_shadow <= current;
            idx        <= '0;
            spike_q    <= '0;
          end
        end
        UPDATE: begin
          state[idx]   <= upd_next;
          spike_q[idx] <= upd_fire;
          idx          <= (idx == LAST_IDX) ? '0 : idx + IDXW'(1);
        end
        default: ;
      endcase
      // Config writes land on this edge; the datapath above already sampled the old value.
      if (cfg_we) begin
        if (cfg_addr[IDXW] == CFG_SEL_LEAK)
          leak_shift <= cfg_data;
        else if (int'(cfg_addr[IDXW-1:0]) < NUM_NEURONS)
          thr[cfg_addr[IDXW-1:0]] <= cfg_data;
      end
    end
  end

  assign busy        = (fsm_q != IDLE);
  assign spike_valid = (fsm_q == REPORT);
  assign spike_vec   = spike_q;
  assign overrun     = overrun_q;
  assign fsm_state   = fsm_q;

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Scoreboard bench for lif_neuron_scheduler: a reference model predicts each sweep's spike vector.
module tb_lif_neuron_scheduler;
  import lif_neuron_scheduler_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = $clog2(N) + 1;

  logic             clk;
  logic             rst_n;
  logic             step;
  logic [N*W-1:0]   current;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [W-1:0]     cfg_data;
  logic             busy;
  logic             spike_valid;
  logic             spike_ready;
  logic [N-1:0]     spike_vec;
  logic             overrun;
  sched_state_t     fsm_state;

  lif_neuron_scheduler #(.NUM_NEURONS(N), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .step        (step),
    .current     (current),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .busy        (busy),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spike_vec   (spike_vec),
    .overrun     (overrun),
    .fsm_state   (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_q[$];
  int m_state [N];
  int m_thr   [N];
  int m_leak;

  function automatic logic [N*W-1:0] all_cur(input int v);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0;
      m_thr[i]   = 32;
    end
    m_leak = 1;
    exp_q.delete();
  endtask

  function automatic logic [N-1:0] model_sweep(input logic [N*W-1:0] cur);
    logic [N-1:0] vec;
    int leak, nxt;
    for (int i = 0; i < N; i++) begin
      vec[i] = (m_state[i] >= m_thr[i]);
      leak   = (vec[i] || m_leak >= W) ? 0 : (m_state[i] >> m_leak);
      nxt    = int'(cur[i*W +: W]) + leak;
      if (nxt > 255) nxt = 255;
      m_state[i] = nxt;
    end
    return vec;
  endfunction

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; step = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cfg_write(input logic [AW-1:0] addr, input logic [W-1:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    if (addr[AW-1]) m_leak = int'(data);
    else if (int'(addr[AW-2:0]) < N) m_thr[addr[AW-2:0]] = int'(data);
  endtask

  task automatic apply_step(input logic [N*W-1:0] cur);
    @(negedge clk);
    current = cur; step = 1'b1;
    exp_q.push_back(model_sweep(cur));
    @(negedge clk);
    step = 1'b0;
    current = {$urandom, $urandom};
  endtask

  // Scoreboard: pop on the handshake cycle and compare.
  task automatic wait_report(input string name);
    logic [N-1:0] exp;
    for (int k = 0; k < 50; k++) begin
      if (spike_valid === 1'b1 && spike_ready === 1'b1) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (spike_vec !== exp) begin
          errors++;
          $display("FAIL %s spike_vec: got %b expected %b", name, spike_vec, exp);
        end
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL %s report timeout: spike_valid=%b expected 1 within 50 cycles", name, spike_valid);
  endtask

  task automatic check_states(input string name);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (int'(dut.state[i]) !== m_state[i]) begin
        errors++;
        $display("FAIL %s state[%0d]: got %0d expected %0d", name, i, dut.state[i], m_state[i]);
      end
    end
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; step = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({spike_valid, busy, overrun, spike_vec} !== '0 || fsm_state !== IDLE) begin
      errors++;
      $display("FAIL reset outputs: got valid=%b busy=%b ovr=%b vec=%b fsm=%0d expected all 0/IDLE",
               spike_valid, busy, overrun, spike_vec, fsm_state);
    end
    checks++;
    if (dut.thr[0] !== 8'd32 || dut.thr[N-1] !== 8'd32 || dut.leak_shift !== 8'd1 || dut.idx !== '0) begin
      errors++;
      $display("FAIL reset config: got thr0=%0d thr3=%0d leak=%0d idx=%0d expected 32 32 1 0",
               dut.thr[0], dut.thr[N-1], dut.leak_shift, dut.idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_states("reset");
  endtask

  task automatic test_basic_sweep();
    int cnt = 0;
    do_reset();
    spike_ready = 1'b1;
    apply_step(all_cur(10));
    for (int k = 0; k < 20; k++) begin
      if (spike_valid === 1'b1) break;
      if (busy === 1'b1) cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != N) begin
      errors++;
      $display("FAIL basic busy cycles: got %0d expected %0d", cnt, N);
    end
    wait_report("basic");
    check_states("basic");
  endtask

  task automatic test_fire_no_leak();
    logic [N*W-1:0] cur = '0;
    cur[2*W +: W] = 8'd40;
    do_reset();
    spike_ready = 1'b1;
    apply_step(cur);
    wait_report("fire1");
    apply_step(cur);
    wait_report("fire2");
    checks++;
    if (dut.state[2] !== 8'd40) begin
      errors++;
      $display("FAIL fire state2: got %0d expected 40", dut.state[2]);
    end
    check_states("fire");
  endtask

  task automatic test_saturation();
    do_reset();
    spike_ready = 1'b1;
    for (int i = 0; i < N; i++) cfg_write(AW'(i), 8'd255);
    apply_step(all_cur(200));
    wait_report("sat1");
    apply_step(all_cur(200));
    wait_report("sat2");
    checks++;
    if (dut.state[0] !== 8'd255) begin
      errors++;
      $display("FAIL sat state0: got %0d expected 255", dut.state[0]);
    end
    check_states("sat");
  endtask

  task automatic test_backpressure();
    logic [N-1:0] held;
    int seen_busy = 0;
    do_reset();
    spike_ready = 1'b1;
    apply_step(all_cur(50));
    wait_report("bp1");
    spike_ready = 1'b0;
    apply_step(all_cur(50));
    for (int k = 0; k < 20 && spike_valid !== 1'b1; k++) @(negedge clk);
    held = spike_vec;
    for (int k = 0; k < 5; k++) begin
      step = (k == 2);
      @(negedge clk);
      checks++;
      if (spike_valid !== 1'b1 || spike_vec !== held) begin
        errors++;
        $display("FAIL bp hold cycle %0d: got valid=%b vec=%b expected 1 %b", k, spike_valid, spike_vec, held);
      end
    end
    step = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp overrun: got %b expected 1", overrun);
    end
    spike_ready = 1'b1;
    wait_report("bp2");
    for (int k = 0; k < 8; k++) begin
      if (busy === 1'b1) seen_busy++;
      @(negedge clk);
    end
    checks++;
    if (seen_busy != 0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp after ready: got busy_cycles=%0d overrun=%b expected 0 1", seen_busy, overrun);
    end
    check_states("bp");
  endtask

  task automatic test_cfg_leak();
    do_reset();
    spike_ready = 1'b1;
    cfg_write(AW'(1), 8'd5);
    cfg_write({1'b1, {(AW-1){1'b0}}}, 8'd8);
    apply_step(all_cur(6));
    wait_report("cfg1");
    apply_step(all_cur(6));
    wait_report("cfg2");
    check_states("cfg");
  endtask

  task automatic test_reset_mid_sweep();
    int bad = 0;
    do_reset();
    spike_ready = 1'b1;
    apply_step(all_cur(20));
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (spike_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset outputs: got %0d bad cycles expected 0", bad);
    end
    check_states("midreset_clear");
    apply_step(all_cur(20));
    wait_report("midreset_sweep");
    check_states("midreset_after");
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] cur;
    do_reset();
    spike_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < N; i++) cur[i*W +: W] = W'($urandom_range(0, 60));
      apply_step(cur);
      wait_report("b2b");
    end
    check_states("b2b");
  endtask

  initial begin
    rst_n = 1'b0; step = 1'b0; current = '0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; spike_ready = 1'b1;
    model_reset();
    test_reset();
    test_basic_sweep();
    test_fire_no_leak();
    test_saturation();
    test_backpressure();
    test_cfg_leak();
    test_reset_mid_sweep();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover reports: got %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lif_neuron_scheduler.md
LIF_NEURON_SCHEDULER -- requirements
Module: lif_neuron_scheduler

Interface
REQ-001 Parameter NUM_NEURONS, default 4, SHALL set the number of virtual neurons time-multiplexed onto one update datapath; legal range 2..16.
REQ-002 Parameter W, default 8, SHALL set the membrane, current and threshold width.
REQ-003 clk  in  1  clock; all state updates occur on the rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 step  in  1  single-cycle pulse starting one timestep sweep.
REQ-006 current  in  NUM_NEURONS*W  per-neuron input current; neuron i occupies bits [i*W +: W].
REQ-007 cfg_we  in  1  configuration write strobe.
REQ-008 cfg_addr  in  clog2(NUM_NEURONS)+1  MSB=0 selects a threshold entry (low bits = neuron index); MSB=1 selects leak_shift.
REQ-009 cfg_data  in  W  configuration write data.
REQ-010 busy  out  1  high while a sweep is in progress.
REQ-011 spike_valid  out  1  spike report available.
REQ-012 spike_ready  in  1  consumer accepts the report.
REQ-013 spike_vec  out  NUM_NEURONS  bit i = neuron i fired in the reported timestep.
REQ-014 overrun  out  1  sticky flag; set when a step is dropped.

Function
REQ-015 FSM states SHALL be IDLE, UPDATE and REPORT.
REQ-016 IDLE plus step SHALL capture current into a shadow register, clear idx to 0 and enter UPDATE on the next cycle.
REQ-017 UPDATE SHALL process neuron idx in each cycle, so a sweep takes NUM_NEURONS cycles; after the last index the FSM SHALL enter REPORT.
REQ-018 Per neuron: fire = (state[i] >= thr[i]) evaluated on the pre-update state; fire SHALL be written to spike_vec bit i.
REQ-019 Per neuron: next = cur[i] + (fire ? 0 : state[i] >> leak_shift), computed W+1 bits wide and saturated to 2^W-1; state[i] <= next.
REQ-020 A leak_shift value >= W SHALL yield a leak term of 0.
REQ-021 REPORT SHALL assert spike_valid with a stable spike_vec until the cycle where spike_valid and spike_ready are both high; the FSM SHALL then return to IDLE.
REQ-022 A report SHALL be issued every sweep, including when spike_vec is all zeros.
REQ-023 busy SHALL be high in UPDATE and REPORT and low in IDLE.
REQ-024 A step in UPDATE or REPORT SHALL be ignored and SHALL set overrun; overrun SHALL be cleared only by reset.
REQ-025 A configuration write SHALL take effect on the next clock edge in any state; when a sweep reads an entry in the same cycle it is written, the sweep SHALL use the old value.
REQ-026 A cfg_addr that selects a threshold index >= NUM_NEURONS SHALL be ignored.
REQ-027 The shadow current SHALL remain unchanged during a sweep, regardless of changes on the current input.

Reset
REQ-028 During reset all state[i] SHALL be 0, thr[i] SHALL be 32, leak_shift SHALL be 1, the FSM SHALL be IDLE and idx SHALL be 0.
REQ-029 During reset spike_valid, busy, overrun and spike_vec SHALL be 0.
REQ-030 Reset asserted mid-sweep or mid-report SHALL abort the sweep without issuing a report.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the reset threshold (32), the reset leak_shift (1) and the cfg_addr MSB decode constant.
REQ-032 The per-neuron arithmetic SHALL be a combinational sub-module lif_update with inputs state, current, threshold and leak_shift, and outputs next and fire.
REQ-033 state and thr SHALL be register arrays indexed by idx; no memory macro is required.

Verification
REQ-034 Reset, then step with every current = 10, spike_ready=1 -> busy for 4 cycles, spike_vec=0000, then state=10 for every neuron.
REQ-035 Neuron 2 current=40 for two steps -> first report spike_vec=0000 (state 40); second report bit 2=1 and state[2]=40 (no leak added).
REQ-036 Set state to 200 with current=200, leak_shift=1 -> next saturates to 255, not 44.
REQ-037 Hold spike_ready=0 for 5 cycles in REPORT and pulse step during that time -> spike_vec stable, overrun=1, no second sweep after ready.
REQ-038 Write thr[1]=5 and leak_shift=8, then apply current=6 twice -> second report bit 1=1, and the leak term contributed 0.
REQ-039 Assert rst_n=0 in the middle of UPDATE -> no spike_valid, all states 0, next step sweeps normally.
